// File: rtl/pwm_brightness_pkg.sv
// Shared types and default constants for the button-stepped PWM brightness controller.
package pwm_brightness_pkg;

    // Debounce FSM states: two stable states, each with a qualifying wait state.
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_e;

    // 20 ms of stable input at 50 MHz.
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_LEVEL_BITS      = 3;
    localparam int DEF_PWM_BITS        = 8;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus counting debounce FSM for a raw push-button.
// Emits a one-cycle Step pulse per accepted press; releases are qualified
// the same way but produce no pulse. Reusable for any active-high button.
module button_debounce
    import pwm_brightness_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic Clk,
    input  logic nReset,
    input  logic Button,
    output logic Step,
    output logic Pressed
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s1_q, s2_q;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_q, step_d;

    // Synchroniser: only s2 is safe to use downstream.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= Button;
            s2_q <= s1_q;
        end
    end

    // FSM state, stability counter and registered step pulse.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
        end
    end

    // Next-state logic: any glitch in a wait state falls back to the opposite
    // stable state, so the full window restarts on the next change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = 1'b0;
        case (state_q)
            RELEASED: begin
                cnt_d = '0;
                if (s2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!s2_q) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    step_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                cnt_d = '0;
                if (!s2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (s2_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign Step    = step_q;
    assign Pressed = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/pwm_brightness_ctrl.sv
// Button-stepped LED brightness: each debounced press advances a wrapping
// level, which sets the duty of a free-running PWM. Duty is swapped in only
// when the PWM counter wraps, so every emitted period is complete.
module pwm_brightness_ctrl
    import pwm_brightness_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LEVEL_BITS      = DEF_LEVEL_BITS,
    parameter int PWM_BITS        = DEF_PWM_BITS
) (
    input  logic                  Clk,
    input  logic                  nReset,
    input  logic                  Button,
    output logic                  Step,
    output logic [LEVEL_BITS-1:0] Level,
    output logic                  PWM
);

    logic                  step;
    logic                  unused_pressed;
    logic [LEVEL_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0]   cnt_q, cnt_d;
    logic [PWM_BITS-1:0]   duty_q, duty_d;
    logic                  pwm_q, pwm_d;
    logic                  wrap;

    // The debounced level itself is not needed here; only the press pulse is.
    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .Clk    (Clk),
        .nReset (nReset),
        .Button (Button),
        .Step   (step),
        .Pressed(unused_pressed)
    );

    // Level, PWM counter, active duty and registered LED drive.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            level_q <= '0;
            cnt_q   <= '0;
            duty_q  <= '0;
            pwm_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            pwm_q   <= pwm_d;
        end
    end

    // Step is registered inside the debouncer, so the visible level is
    // level_q plus the pulse: it changes on the same edge that raises Step,
    // and level_q catches up one edge later when Step drops.
    always_comb begin
        level_d = level_q + LEVEL_BITS'(step);
        cnt_d   = cnt_q + PWM_BITS'(1);
        wrap    = &cnt_q;
        duty_d  = wrap ? {level_d, {(PWM_BITS - LEVEL_BITS){1'b0}}} : duty_q;
        pwm_d   = (cnt_d < duty_d);
    end

    assign Step  = step;
    assign Level = level_d;
    assign PWM   = pwm_q;

endmodule

// File: tb/tb_pwm_brightness_ctrl.sv
// Scoreboard bench for pwm_brightness_ctrl with a short debounce window and
// a 16-cycle PWM period.
module tb_pwm_brightness_ctrl;

    localparam int DB     = 4;
    localparam int LB     = 3;
    localparam int PB     = 4;
    localparam int PERIOD = 1 << PB;

    logic          Clk = 1'b0;
    logic          nReset;
    logic          Button;
    logic          Step;
    logic [LB-1:0] Level;
    logic          PWM;

    int cyc      = 0;
    int rel_cyc  = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int cyc;
        int lvl;
    } step_exp_t;

    step_exp_t sb_q[$];

    pwm_brightness_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .LEVEL_BITS     (LB),
        .PWM_BITS       (PB)
    ) dut (
        .Clk   (Clk),
        .nReset(nReset),
        .Button(Button),
        .Step  (Step),
        .Level (Level),
        .PWM   (PWM)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // PWM counter value left by the most recent edge, counted from reset release.
    function automatic int pcnt();
        return (cyc - rel_cyc) % PERIOD;
    endfunction

    task automatic push_exp(input int at_cyc, input int lvl);
        step_exp_t e;
        e.cyc = at_cyc;
        e.lvl = lvl;
        sb_q.push_back(e);
    endtask

    // Every Step pulse must match the next scoreboard entry in time and level.
    always @(negedge Clk) begin
        step_exp_t e;
        if (nReset === 1'b1 && Step === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_step", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check_eq("step_cycle", cyc, e.cyc);
                check_eq("step_level", int'(Level), e.lvl);
            end
        end
    end

    task automatic wait_cnt(input int k);
        int guard = 0;
        while (pcnt() != k && guard < 2 * PERIOD) begin
            @(negedge Clk);
            guard++;
        end
        check_eq("wait_cnt_reached", pcnt(), k);
    endtask

    // Count PWM highs over one full period aligned to counter 0.
    task automatic measure(input string tag, input int exp);
        int highs = 0;
        wait_cnt(0);
        for (int i = 0; i < PERIOD; i++) begin
            highs += int'(PWM);
            @(negedge Clk);
        end
        check_eq(tag, highs, exp);
    endtask

    // Clean press held 20 cycles; Step due 6 negedges after Button rises.
    task automatic press(input int lvl);
        push_exp(cyc + DB + 2, lvl);
        Button = 1'b1;
        repeat (20) @(negedge Clk);
        Button = 1'b0;
        repeat (10) @(negedge Clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int pre_highs;
        int bpat[7];
        int rpat[7];
        bpat = '{1, 1, 0, 1, 1, 1, 1};
        rpat = '{0, 0, 1, 0, 0, 0, 0};
        Button = 1'b0;
        nReset = 1'b1;

        // Asynchronous reset mid-cycle
        repeat (3) @(negedge Clk);
        #2 nReset = 1'b0;
        #1;
        check_eq("rst_pwm", int'(PWM), 0);
        check_eq("rst_step", int'(Step), 0);
        check_eq("rst_level", int'(Level), 0);
        repeat (2) @(negedge Clk);
        nReset  = 1'b1;
        rel_cyc = cyc;

        measure("duty_l0", 0);

        // Press accepted mid-period: old duty finishes, new duty starts at counter 0
        wait_cnt(3);
        push_exp(cyc + DB + 2, 1);
        Button = 1'b1;
        repeat (6) @(negedge Clk);
        Button    = 1'b0;
        pre_highs = 0;
        while (pcnt() != 0) begin
            pre_highs += int'(PWM);
            @(negedge Clk);
        end
        check_eq("bnd_old_period", pre_highs, 0);
        check_eq("bnd_cnt0", int'(PWM), 1);
        @(negedge Clk);
        check_eq("bnd_cnt1", int'(PWM), 1);
        @(negedge Clk);
        check_eq("bnd_cnt2", int'(PWM), 0);
        repeat (10) @(negedge Clk);

        measure("duty_l1", 2);

        // Bouncy press: only the last rising sample starts the window
        push_exp(cyc + 3 + DB + 2, 2);
        for (int i = 0; i < 7; i++) begin
            Button = bpat[i][0];
            @(negedge Clk);
        end
        repeat (10) @(negedge Clk);
        for (int i = 0; i < 7; i++) begin
            Button = rpat[i][0];
            @(negedge Clk);
        end
        repeat (12) @(negedge Clk);
        measure("duty_l2", 4);

        // Walk up to the top level, then wrap to zero
        for (int l = 3; l <= 7; l++) press(l);
        measure("duty_l7", 14);
        press(0);
        measure("duty_wrap0", 0);
        check_eq("level_wrap0", int'(Level), 0);

        // Reset while the FSM is qualifying a press
        press(1);
        measure("duty_relvl1", 2);
        wait_cnt(13);
        Button = 1'b1;
        repeat (3) @(negedge Clk);
        check_eq("prw_pwm_before", int'(PWM), 1);
        #2 nReset = 1'b0;
        #1;
        check_eq("prw_rst_pwm", int'(PWM), 0);
        check_eq("prw_rst_step", int'(Step), 0);
        check_eq("prw_rst_level", int'(Level), 0);
        @(negedge Clk);
        @(negedge Clk);
        nReset  = 1'b1;
        rel_cyc = cyc;
        push_exp(cyc + DB + 2, 1);
        @(negedge Clk);
        @(negedge Clk);
        @(negedge Clk);
        check_eq("post_rst_pwm_low", int'(PWM), 0);
        repeat (9) @(negedge Clk);
        Button = 1'b0;
        repeat (12) @(negedge Clk);
        measure("duty_post_rst", 2);

        check_eq("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
